// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Instruction-memory load controller. It receives a framed word
//             stream (length header, N program words, optional checksum) and
//             writes each program word to successive imem addresses. The core
//             is held in reset until a complete, valid image has been loaded.
//  Build    : define IMEM_LOADER_CSUM_EN to expect a trailing checksum word
//             (mod-2^32 sum of the data words) after every image.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             imem_wr_en        - word strobe, one word per strobed cycle
//             imem_data_in      - 32-bit word for the strobe
//             mem_we/mem_addr/mem_wdata - imem write port (1-cycle latency)
//             core_hold         - keeps the core in reset while high
//             load_done         - image loaded and valid
//             load_err          - framing or checksum error
//             word_cnt          - data words written in the current load
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_wr_en,
    input  logic [31:0]           imem_data_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    // LEN shares IDLE's encoding role: the header is decoded in the same
    // cycle it is strobed, so LEN never needs to be occupied on its own.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     word_cnt_q;
    logic [ADDR_WIDTH:0]     word_cnt_d;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [31:0]             mem_wdata_q;
    logic                    core_hold_q;
    logic                    load_done_q;
    logic                    load_err_q;
    logic                    len_ok;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]             sum_q;
`endif

    assign word_cnt_d = word_cnt_q + 1'b1;

    // Full 32-bit compare so a huge header can never alias into range.
    assign len_ok = (imem_data_in != 32'd0) && (imem_data_in <= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            // Write enable is a one-cycle pulse per accepted data word.
            mem_we_q <= 1'b0;
            case (state_q)
                // A strobe in DONE/ERR restarts the load exactly like IDLE.
                ST_IDLE, ST_LEN, ST_DONE, ST_ERR: begin
                    if (imem_wr_en) begin
                        word_cnt_q  <= '0;
                        load_done_q <= 1'b0;
                        core_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                        sum_q       <= '0;
`endif
                        if (len_ok) begin
                            len_q      <= imem_data_in[ADDR_WIDTH:0];
                            load_err_q <= 1'b0;
                            state_q    <= ST_DATA;
                        end else begin
                            load_err_q <= 1'b1;
                            state_q    <= ST_ERR;
                        end
                    end
                end
                ST_DATA: begin
                    if (imem_wr_en) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
                        mem_wdata_q <= imem_data_in;
                        word_cnt_q  <= word_cnt_d;
`ifdef IMEM_LOADER_CSUM_EN
                        sum_q       <= sum_q + imem_data_in;
`endif
                        if (word_cnt_d == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_q     <= ST_CSUM;
`else
                            // Completion lands together with the last write.
                            state_q     <= ST_DONE;
                            load_done_q <= 1'b1;
                            core_hold_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (imem_wr_en) begin
                        if (imem_data_in == sum_q) begin
                            state_q     <= ST_DONE;
                            load_done_q <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q     <= ST_ERR;
                            load_err_q  <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = core_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Expected imem writes are
//             queued as data words are driven and popped by a monitor when
//             mem_we is seen; status outputs are checked inline per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 256;

    logic                  clk;
    logic                  rst;
    logic                  imem_wr_en;
    logic [31:0]           imem_data_in;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  core_hold;
    logic                  load_done;
    logic                  load_err;
    logic [ADDR_WIDTH:0]   word_cnt;

    int vectors;
    int miscompares;

    logic [ADDR_WIDTH+31:0] exp_q[$];
    logic [31:0]            img [0:DEPTH-1];

    imem_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_wr_en   (imem_wr_en),
        .imem_data_in (imem_data_in),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .word_cnt     (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every mem_we pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [ADDR_WIDTH+31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, e[ADDR_WIDTH+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic strobe(input logic [31:0] w);
        imem_wr_en   = 1'b1;
        imem_data_in = w;
        @(posedge clk); #1;
        imem_wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sample after the negedge so the write monitor has already run.
    task automatic sample();
        @(negedge clk); #1;
    endtask

    // Drives header, img[0..n-1] and (when built in) the checksum word,
    // queueing the expected writes as the data words go out.
    task automatic load_image(input int n, input int gap);
        logic [31:0] sum;
        sum = 32'd0;
        strobe(32'(n));
        for (int i = 0; i < n; i++) begin
            idle(gap);
            exp_q.push_back({ADDR_WIDTH'(i), img[i]});
            sum = sum + img[i];
            strobe(img[i]);
        end
`ifdef IMEM_LOADER_CSUM_EN
        idle(gap);
        strobe(sum);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_wr_en = 1'b0; imem_data_in = '0;
        repeat (2) @(posedge clk);
        sample();
        vectors++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 8'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_mem: got we=%b addr=%0d data=%h, required 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        vectors++;
        if ({core_hold, load_done, load_err, word_cnt} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
            miscompares++;
            $display("FAIL reset_status: got hold=%b done=%b err=%b cnt=%0d, required 1/0/0/0",
                     core_hold, load_done, load_err, word_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        img[0] = 32'h00500093; img[1] = 32'h00100113; img[2] = 32'h002081B3;
        load_image(3, 0);
        sample();
        vectors++;
        if ({load_done, core_hold, load_err, word_cnt} !== {1'b1, 1'b0, 1'b0, 9'd3}) begin
            miscompares++;
            $display("FAIL basic_done: got done=%b hold=%b err=%b cnt=%0d, required 1/0/0/3",
                     load_done, core_hold, load_err, word_cnt);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        img[0] = 32'h10; img[1] = 32'h20;
        load_image(2, 0);
        sample();
        vectors++;
        if ({load_done, load_err, core_hold} !== 3'b100) begin
            miscompares++;
            $display("FAIL csum_good: got done=%b err=%b hold=%b, required 1/0/0", load_done, load_err, core_hold);
        end
        strobe(32'd2);
        exp_q.push_back({8'd0, 32'h10}); strobe(32'h10);
        exp_q.push_back({8'd1, 32'h20}); strobe(32'h20);
        strobe(32'h31);
        sample();
        vectors++;
        if ({load_done, load_err, core_hold} !== 3'b011) begin
            miscompares++;
            $display("FAIL csum_bad: got done=%b err=%b hold=%b, required 0/1/1", load_done, load_err, core_hold);
        end
    endtask
`endif

    task automatic test_len_bounds();
        strobe(32'd0);
        sample();
        vectors++;
        if ({load_err, load_done, core_hold} !== 3'b101) begin
            miscompares++;
            $display("FAIL len_zero: got err=%b done=%b hold=%b, required 1/0/1", load_err, load_done, core_hold);
        end
        strobe(32'd257);
        sample();
        vectors++;
        if ({load_err, load_done, core_hold} !== 3'b101) begin
            miscompares++;
            $display("FAIL len_over: got err=%b done=%b hold=%b, required 1/0/1", load_err, load_done, core_hold);
        end
        strobe(32'h8000_0001);
        sample();
        vectors++;
        if (load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL len_huge: got err=%b, required 1", load_err);
        end
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        load_image(DEPTH, 0);
        sample();
        vectors++;
        if ({load_done, load_err, core_hold, word_cnt} !== {1'b1, 1'b0, 1'b0, 9'd256}) begin
            miscompares++;
            $display("FAIL len_full: got done=%b err=%b hold=%b cnt=%0d, required 1/0/0/256",
                     load_done, load_err, core_hold, word_cnt);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL len_full_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_gapped();
        img[0] = 32'hA5A5_0001; img[1] = 32'h5A5A_0002;
        load_image(2, 5);
        sample();
        vectors++;
        if ({load_done, core_hold, load_err, word_cnt} !== {1'b1, 1'b0, 1'b0, 9'd2}) begin
            miscompares++;
            $display("FAIL gapped_done: got done=%b hold=%b err=%b cnt=%0d, required 1/0/0/2",
                     load_done, core_hold, load_err, word_cnt);
        end
    endtask

    task automatic test_reset_mid();
        strobe(32'd4);
        exp_q.push_back({8'd0, 32'h1111_1111}); strobe(32'h1111_1111);
        exp_q.push_back({8'd1, 32'h2222_2222}); strobe(32'h2222_2222);
        // Reset coincides with a strobe; that word must be discarded.
        rst = 1'b1; imem_wr_en = 1'b1; imem_data_in = 32'd1;
        @(posedge clk); #1;
        rst = 1'b0; imem_wr_en = 1'b0;
        sample();
        vectors++;
        if ({mem_we, mem_addr, core_hold, load_done, load_err, word_cnt} !==
            {1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
            miscompares++;
            $display("FAIL midreset_state: got we=%b addr=%0d hold=%b done=%b err=%b cnt=%0d, required 0/0/1/0/0/0",
                     mem_we, mem_addr, core_hold, load_done, load_err, word_cnt);
        end
        img[0] = 32'hDEADBEEF;
        load_image(1, 0);
        sample();
        vectors++;
        if ({load_done, core_hold, word_cnt} !== {1'b1, 1'b0, 9'd1}) begin
            miscompares++;
            $display("FAIL midreset_reload: got done=%b hold=%b cnt=%0d, required 1/0/1",
                     load_done, core_hold, word_cnt);
        end
    endtask

    task automatic test_restart();
        strobe(32'd1);
        sample();
        vectors++;
        if ({load_done, core_hold, load_err, word_cnt} !== {1'b0, 1'b1, 1'b0, 9'd0}) begin
            miscompares++;
            $display("FAIL restart_hdr: got done=%b hold=%b err=%b cnt=%0d, required 0/1/0/0",
                     load_done, core_hold, load_err, word_cnt);
        end
        exp_q.push_back({8'd0, 32'h12345678});
        strobe(32'h12345678);
`ifdef IMEM_LOADER_CSUM_EN
        strobe(32'h12345678);
`endif
        sample();
        vectors++;
        if ({load_done, core_hold, word_cnt} !== {1'b1, 1'b0, 9'd1}) begin
            miscompares++;
            $display("FAIL restart_done: got done=%b hold=%b cnt=%0d, required 1/0/1",
                     load_done, core_hold, word_cnt);
        end
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL final_drain: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        test_len_bounds();
        test_gapped();
        test_reset_mid();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Instruction-memory load controller: the receiving end of the `imem_wr_en` / `imem_data_in` word stream that a host or testbench drives into the `risc_v` top. It frames the stream as a length header, N program words and an optional checksum. It writes each word to successive instruction-memory addresses and holds the core in reset until a complete, valid image is loaded.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width.
- `DEPTH`, default 256: number of words in imem; must be ≤ 2^ADDR_WIDTH.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_wr_en`, in, 1: word strobe; one word accepted per cycle it is high.
- `imem_data_in`, in, 32: word accompanying the strobe.
- `mem_we`, out, 1: imem write enable.
- `mem_addr`, out, ADDR_WIDTH: imem word address.
- `mem_wdata`, out, 32: imem write data.
- `core_hold`, out, 1: high keeps the core in reset; ORed with `rst` at the top.
- `load_done`, out, 1: image loaded and valid.
- `load_err`, out, 1: framing or checksum error.
- `word_cnt`, out, ADDR_WIDTH+1: data words written in the current load.

## Operation
States: IDLE, LEN, DATA, CSUM, DONE, ERR.

- **Reset.** Enters IDLE. Outputs: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=1, `load_done`=0, `load_err`=0, `word_cnt`=0.
- **IDLE/LEN.** The first strobed word is the length N, taken as an unsigned 32-bit value.
  - N=0 or N>DEPTH → ERR.
  - Otherwise N is latched and the state goes to DATA.
- **DATA.** Each strobed word is written at address `word_cnt`, then `word_cnt` increments.
  - After word N: go to CSUM if checksum is enabled, else to DONE.
  - A running sum, modulo 2^32, accumulates every data word.
- **CSUM.** The next strobed word is compared with the running sum: equal → DONE, unequal → ERR.
- **DONE.** `core_hold`=0, `load_done`=1.
- **ERR.** `core_hold`=1, `load_err`=1.
- **Restart from DONE/ERR.** A strobe in DONE or ERR is treated as a new length word.
  - `load_done`, `load_err`, `word_cnt` and the sum clear.
  - `core_hold` returns to 1 in the same cycle.
  - The new length is checked exactly as in IDLE.
- **Idle cycles.** Cycles with `imem_wr_en`=0 are ignored in every state; gaps of any length are legal.
- **Memory contents.** Never cleared by this block. A failed load leaves partially written words in imem, which is acceptable because `core_hold` stays high.

## Timing
- **Write latency: 1 cycle.** A word strobed at edge k drives `mem_we`=1 with its `mem_addr`/`mem_wdata` during cycle k→k+1. `mem_we` is a single-cycle pulse per data word.
- **Back-to-back.** Strobes on consecutive cycles are sustained at one word per cycle with no stall.
- **Header/checksum words.** Length and checksum words never assert `mem_we`.
- **Completion.**
  - `load_done` and the falling edge of `core_hold` register on the edge that accepts the last data word (no checksum) or the checksum word.
  - They are visible one cycle after that strobe, in the same cycle as the last `mem_we` when no checksum is used.
- **Errors.** `load_err` registers on the edge accepting the offending word.
- **Reset mid-load.** `rst` high at any edge overrides everything: all outputs return to reset values at that edge, and any in-flight `mem_we` is dropped.
- **Simultaneous `rst` and `imem_wr_en`.** `rst` wins and the word is discarded.
- **Address range.** `mem_addr` never exceeds N−1 ≤ DEPTH−1. No wrap-around is possible because N is range-checked.

## Configuration
- **`IMEM_LOADER_CSUM_EN` defined.**
  - The CSUM state and the 32-bit running-sum register are compiled in.
  - Each image is followed by one checksum word equal to the modulo-2^32 sum of the data words.
- **`IMEM_LOADER_CSUM_EN` undefined.**
  - No CSUM state and no sum register.
  - DATA goes directly to DONE after word N.
  - A word strobed after DONE is a new length header.

## Test plan
- **Basic 3-word load, checksum off.** Strobe 3, 0x00500093, 0x00100113, 0x002081B3 on consecutive cycles.
  - `mem_we` pulses at addresses 0, 1, 2 with those data.
  - `load_done`=1 and `core_hold`=0 one cycle after the last strobe; `word_cnt`=3.
- **Checksum on, good and bad.** Strobe 2, 0x00000010, 0x00000020, then a checksum word.
  - Checksum 0x00000030 → `load_done`=1.
  - Checksum 0x00000031 → `load_err`=1, `core_hold`=1.
- **Length bounds.**
  - Length 0 → `load_err`=1 with no `mem_we`.
  - Length DEPTH+1 (257) → `load_err`=1 with no `mem_we`.
  - Length 256 followed by 256 words → last write at address 255, then `load_done`=1.
- **Gapped stream.** Strobe 2 and two words, with 5 idle cycles between strobes → identical writes and completion as the back-to-back case.
- **Reset mid-load.** Strobe 4 and two words, assert `rst` for 1 cycle, then strobe 1 and 0xDEADBEEF.
  - All outputs reach reset values after the reset edge.
  - The new load writes 0xDEADBEEF at address 0 and sets `load_done`=1.
- **Restart after DONE.** After a completed load, strobe 1 and 0x12345678.
  - `load_done` falls and `core_hold` rises on the length strobe.
  - A single write to address 0 follows, then `load_done`=1 again.
